// File: rtl/truth_table_checker.sv
// Response analyzer for exhaustive N_IN-input combinational sweeps.
// Checks samples against a golden table and tracks minterm coverage.
module truth_table_checker #(
  parameter int                  N_IN        = 4,
  parameter logic [(1<<N_IN)-1:0] TRUTH_TABLE = 16'h6996,
  parameter int                  CNT_W       = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_IN-1:0]      in_vec,
  input  logic                 in_f,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CNT_W-1:0]     err_count,
  output logic                 first_err_valid,
  output logic [N_IN-1:0]      first_err_vec,
  output logic [(1<<N_IN)-1:0] coverage
);

  localparam int DEPTH = 1 << N_IN;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [DEPTH-1:0]   cov_q, cov_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic               fev_q;
  logic [N_IN-1:0]    fvec_q;
  logic               pass_q;
  logic               acc;
  logic               mism;

  // Next coverage / error count for the sample on the inputs this cycle
  always_comb begin
    acc   = in_valid && (state_q == RUN);
    mism  = (in_f != TRUTH_TABLE[in_vec]);
    cov_d = cov_q;
    err_d = err_q;
    if (acc) begin
      cov_d[in_vec] = 1'b1;
      if (mism && !(&err_q)) begin
        err_d = err_q + CNT_W'(1);
      end
    end
  end

  // Run control FSM with all result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cov_q   <= '0;
      err_q   <= '0;
      fev_q   <= 1'b0;
      fvec_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= RUN;
            cov_q   <= '0;
            err_q   <= '0;
            fev_q   <= 1'b0;
            fvec_q  <= '0;
            pass_q  <= 1'b0;
          end
        end
        RUN: begin
          if (acc) begin
            cov_q <= cov_d;
            err_q <= err_d;
            if (mism && !fev_q) begin
              fev_q  <= 1'b1;
              fvec_q <= in_vec;
            end
            // The sample that fills coverage closes the run
            if (&cov_d) begin
              state_q <= DONE;
              pass_q  <= (err_d == '0);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready        = (state_q == RUN);
  assign busy            = (state_q == RUN);
  assign done            = (state_q == DONE);
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_err_valid = fev_q;
  assign first_err_vec   = fvec_q;
  assign coverage        = cov_q;

endmodule
